branch_target_predictor: RTL and testbench

- Parametrised dynamic branch predictor: a direct-mapped branch target buffer with N-bit saturating direction counters.
- Sits between IF and EX of the pipelined MIPS core.
  - IF looks up the current PC combinationally to obtain the predicted next PC.
  - EX returns the resolved outcome of every control-transfer instruction; the block raises the flush request and trains the table.
- Generalises the fixed 2-bit/fixed-depth scheme to configurable depth, counter width and statistics width, and adds hit/mispredict counters.

---
 rtl/branch_target_predictor_if.sv | 30 +++
 rtl/branch_target_predictor.sv | 100 ++++++++++
 tb/tb_branch_target_predictor.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side bus of the branch target predictor: IF lookup, EX resolution,
// halt gating and statistics readout.
interface branch_target_predictor_if #(
  parameter int STAT_W = 32
) ();
  logic              halt;
  logic [31:0]       if_pc;
  logic [31:0]       pred_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic              ex_valid;
  logic              ex_uncond;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_target;
  logic [31:0]       ex_pred_pc;
  logic              ex_flush;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  // The pipeline core drives lookups and resolutions.
  modport master (
    output halt, if_pc, ex_valid, ex_uncond, ex_pc, ex_target, ex_pred_pc,
    input  pred_pc, pred_hit, pred_taken, ex_flush, stat_branches, stat_mispredicts
  );

  modport slave (
    input  halt, if_pc, ex_valid, ex_uncond, ex_pc, ex_target, ex_pred_pc,
    output pred_pc, pred_hit, pred_taken, ex_flush, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters; combinational
// lookup for IF, training and misprediction flush from EX, plus hit/mispredict statistics.
module branch_target_predictor #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  branch_target_predictor_if.slave   bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [STAT_W-1:0]   branches_q;
  logic [STAT_W-1:0]   mispredicts_q;

  // Lookup reads registered state only, so a same-cycle update is not visible yet.
  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  assign if_idx = bus.if_pc[IDX+1:2];
  assign if_tag = bus.if_pc[31:IDX+2];

  assign bus.pred_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bus.pred_taken = bus.pred_hit && ctr_q[if_idx][CTR_BITS-1];
  assign bus.pred_pc    = bus.pred_taken ? target_q[if_idx] : bus.if_pc + 32'd4;

  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_taken;
  logic             ex_hit;
  logic             train;
  assign ex_idx   = bus.ex_pc[IDX+1:2];
  assign ex_tag   = bus.ex_pc[31:IDX+2];
  assign ex_taken = bus.ex_target != (bus.ex_pc + 32'd4);
  assign ex_hit   = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign train    = bus.ex_valid && !bus.halt;

  assign bus.ex_flush         = train && (bus.ex_pred_pc != bus.ex_target);
  assign bus.stat_branches    = branches_q;
  assign bus.stat_mispredicts = mispredicts_q;

  logic                nxt_valid;
  logic [TAG_W-1:0]    nxt_tag;
  logic [31:0]         nxt_target;
  logic [CTR_BITS-1:0] nxt_ctr;

  always_comb begin
    // NOTE: every output gets its hold value first so no path leaves it unassigned (no latch).
    nxt_valid  = valid_q[ex_idx];
    nxt_tag    = tag_q[ex_idx];
    nxt_target = target_q[ex_idx];
    nxt_ctr    = ctr_q[ex_idx];
    if (ex_hit) begin
      if (bus.ex_uncond) begin
        nxt_ctr    = CTR_MAX;
        nxt_target = bus.ex_target;
      end else if (ex_taken) begin
        nxt_ctr    = (ctr_q[ex_idx] == CTR_MAX) ? CTR_MAX : ctr_q[ex_idx] + CTR_BITS'(1);
        nxt_target = bus.ex_target;
      end else begin
        nxt_ctr    = (ctr_q[ex_idx] == '0) ? '0 : ctr_q[ex_idx] - CTR_BITS'(1);
      end
    end else if (ex_taken || bus.ex_uncond) begin
      // Allocation replaces whatever aliases onto this index.
      nxt_valid  = 1'b1;
      nxt_tag    = ex_tag;
      nxt_target = bus.ex_target;
      nxt_ctr    = bus.ex_uncond ? CTR_MAX : CTR_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is cleared on reset so lookups after reset never hit stale entries;
      // this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (train) begin
      valid_q[ex_idx]  <= nxt_valid;
      tag_q[ex_idx]    <= nxt_tag;
      target_q[ex_idx] <= nxt_target;
      ctr_q[ex_idx]    <= nxt_ctr;
      branches_q       <= branches_q + STAT_W'(1);
      if (bus.ex_flush) mispredicts_q <= mispredicts_q + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed and randomized checks of branch_target_predictor against a table model kept
// as plain integer arrays (index, tag, counter value).
module tb_branch_target_predictor;
  localparam int ENTRIES  = 16;
  localparam int CTR_BITS = 2;
  localparam int STAT_W   = 4;
  localparam int CMAX     = (1 << CTR_BITS) - 1;
  localparam int CHALF    = 1 << (CTR_BITS - 1);
  localparam int SMOD     = 1 << STAT_W;

  logic clk;
  logic rst;
  branch_target_predictor_if #(.STAT_W(STAT_W)) bus ();

  branch_target_predictor #(
    .ENTRIES (ENTRIES),
    .CTR_BITS(CTR_BITS),
    .STAT_W  (STAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int checks = 0;

  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int unsigned m_br;
  int unsigned m_mp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 0;
      m_tgt[i]   = 0;
      m_ctr[i]   = 0;
    end
    m_br = 0;
    m_mp = 0;
  endfunction

  function automatic void model_predict(input int unsigned pc, output bit hit, output bit tk,
                                        output int unsigned npc);
    int unsigned idx;
    idx = (pc / 4) % ENTRIES;
    hit = m_valid[idx] && (m_tag[idx] == pc / (4 * ENTRIES));
    tk  = hit && (m_ctr[idx] >= CHALF);
    npc = tk ? m_tgt[idx] : pc + 4;
  endfunction

  function automatic void model_train(input bit unc, input int unsigned pc,
                                      input int unsigned tgt, input bit flush);
    int unsigned idx;
    bit hit;
    bit taken;
    idx   = (pc / 4) % ENTRIES;
    hit   = m_valid[idx] && (m_tag[idx] == pc / (4 * ENTRIES));
    taken = (tgt != pc + 4);
    if (hit) begin
      if (unc) begin
        m_ctr[idx] = CMAX;
        m_tgt[idx] = tgt;
      end else if (taken) begin
        m_ctr[idx] = (m_ctr[idx] + 1 > CMAX) ? CMAX : m_ctr[idx] + 1;
        m_tgt[idx] = tgt;
      end else begin
        m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
      end
    end else if (taken || unc) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = pc / (4 * ENTRIES);
      m_tgt[idx]   = tgt;
      m_ctr[idx]   = unc ? CMAX : CHALF;
    end
    m_br = (m_br + 1) % SMOD;
    if (flush) m_mp = (m_mp + 1) % SMOD;
  endfunction

  // One clock: drive, check combinational outputs and stats, clock, update model.
  task automatic step(input bit h, input bit v, input bit unc, input int unsigned epc,
                      input int unsigned etgt, input int unsigned epred, input int unsigned ipc);
    bit hit;
    bit tk;
    int unsigned npc;
    bit flush;
    bus.halt       = h;
    bus.ex_valid   = v;
    bus.ex_uncond  = unc;
    bus.ex_pc      = epc;
    bus.ex_target  = etgt;
    bus.ex_pred_pc = epred;
    bus.if_pc      = ipc;
    #1;
    model_predict(ipc, hit, tk, npc);
    flush = v && !h && (epred != etgt);
    check("pred_hit", {31'd0, bus.pred_hit}, {31'd0, hit});
    check("pred_taken", {31'd0, bus.pred_taken}, {31'd0, tk});
    check("pred_pc", bus.pred_pc, npc);
    check("ex_flush", {31'd0, bus.ex_flush}, {31'd0, flush});
    check("stat_branches", 32'(bus.stat_branches), m_br);
    check("stat_mispredicts", 32'(bus.stat_mispredicts), m_mp);
    @(posedge clk);
    if (rst) model_clear();
    else if (v && !h) model_train(unc, epc, etgt, flush);
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned ipc);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, ipc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned epc;
    int unsigned etgt;
    int unsigned epred;
    int unsigned ipc;
    bit hit;
    bit tk;
    bit h;
    bit unc;

    model_clear();
    rst = 1'b1;
    @(negedge clk);
    // Reset, with a coincident training request that must be discarded.
    step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0100, 32'h0040_0014, 32'h0040_0010);
    rst = 1'b0;
    idle(32'h0040_0010);

    // Allocation: miss, taken -> flush, then weakly-taken prediction.
    step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0100, 32'h0040_0014, 32'h0040_0010);
    idle(32'h0040_0010);

    // Hysteresis.
    step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0014, 32'h0040_0100, 32'h0040_0010);
    idle(32'h0040_0010);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0100, 32'h0040_0014, 32'h0040_0010);
    step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0014, 32'h0040_0100, 32'h0040_0010);
    idle(32'h0040_0010);

    // Aliasing on index 0.
    step(1'b0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0200, 32'h0000_0044, 32'h0000_0040);
    step(1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0300, 32'h0000_0084, 32'h0000_0040);
    idle(32'h0000_0080);

    // Halt freezes training and gates flush; then same-cycle lookup sees old contents.
    step(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2000, 32'h0000_1004, 32'h0000_1000);
    idle(32'h0000_1000);
    step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0200, 32'h0040_0100, 32'h0040_0010);
    idle(32'h0040_0010);

    // Statistics wrap after 16 correctly predicted resolutions.
    rst = 1'b1;
    idle(32'h0);
    rst = 1'b0;
    for (int i = 0; i < SMOD; i++)
      step(1'b0, 1'b1, 1'b0, 32'h0040_0010, 32'h0040_0200, 32'h0040_0200, 32'h0040_0010);
    idle(32'h0040_0010);

    // Randomized traffic over a small PC pool so entries hit, alias and saturate.
    for (int i = 0; i < 600; i++) begin
      epc = ($urandom_range(0, 2) * (4 * ENTRIES)) + ($urandom_range(0, ENTRIES - 1) * 4);
      unc = ($urandom_range(0, 4) == 0);
      if (!unc && $urandom_range(0, 1) == 0) etgt = epc + 4;
      else etgt = $urandom_range(0, 255) * 4;
      model_predict(epc, hit, tk, epred);
      if ($urandom_range(0, 9) < 3) epred = $urandom_range(0, 255) * 4;
      ipc = ($urandom_range(0, 2) * (4 * ENTRIES)) + ($urandom_range(0, ENTRIES - 1) * 4);
      h   = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 49) == 0);
      step(h, $urandom_range(0, 3) != 0, unc, epc, etgt, epred, ipc);
    end
    rst = 1'b0;
    idle(32'h0040_0010);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
